imem_loader: RTL and testbench

- Byte-stream writer that fills the single-cycle core's instruction memory over a valid/ready link. It replaces backdoor preloading of instruction memory.
- It sits between a host/UART byte source and the instruction-memory write port.
- It holds the core stalled until a complete, checksum-verified image is written, then releases it.

---
 rtl/mips32_pkg.sv | 22 ++
 rtl/byte_word_asm.sv | 28 ++
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared constants for the instruction-memory loader: address width, loader states,
// and frame layout.
package mips32_pkg;

   localparam int unsigned DEF_ADDR_W = 10;
   localparam int unsigned WORD_BYTES = 4;

   // A frame is START and COUNT, then the payload, then CHECKSUM.
   localparam int unsigned HDR_WORDS = 2;
   localparam int unsigned TRL_WORDS = 1;

   typedef logic [2:0] loader_state_t;

   localparam loader_state_t ST_IDLE  = 3'd0;
   localparam loader_state_t ST_ADDR  = 3'd1;
   localparam loader_state_t ST_COUNT = 3'd2;
   localparam loader_state_t ST_DATA  = 3'd3;
   localparam loader_state_t ST_CHECK = 3'd4;
   localparam loader_state_t ST_DONE  = 3'd5;
   localparam loader_state_t ST_ERROR = 3'd6;

endpackage

// File: rtl/byte_word_asm.sv
// Packs accepted bytes big-endian into 32-bit words; word_valid pulses during the
// cycle that carries the 4th byte, so word is valid combinationally with it.
module byte_word_asm (
   input  logic        clk,
   input  logic        clr,
   input  logic [7:0]  rx_byte,
   input  logic        take,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  cnt_q;
   logic [23:0] sh_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= 2'd0;
         sh_q  <= 24'd0;
      end else if (take) begin
         cnt_q <= cnt_q + 2'd1;
         sh_q  <= {sh_q[15:0], rx_byte};
      end
   end

   assign word       = {sh_q, rx_byte};
   assign word_valid = take && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Receives a START/COUNT/data/CHECKSUM byte frame and writes it into instruction
// memory, keeping the core held until the image has been verified.
module imem_loader
   import mips32_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_x,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [32:0] LIMIT = 33'(1) << ADDR_W;

   loader_state_t     state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   wl_q, wl_d;
   logic [31:0]       csum_q, csum_d;
   logic              rdy_q, rdy_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic        take;
   logic [31:0] word;
   logic        word_valid;
   logic [32:0] end_addr;

   assign take = rx_valid && rdy_q;

   byte_word_asm u_asm (
      .clk        (clk_x),
      .clr        (!rst_n),
      .rx_byte    (rx_data),
      .take       (take),
      .word       (word),
      .word_valid (word_valid)
   );

   // Unwrapped end address so an image running past the top of memory is caught.
   assign end_addr = {1'b0, word} + 33'(base_q);

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      count_d = count_q;
      wl_d    = wl_q;
      csum_d  = csum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (take) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            if (word_valid) begin
               if (|word[31:ADDR_W]) begin
                  state_d = ST_ERROR;
               end else begin
                  base_d  = word[ADDR_W-1:0];
                  state_d = ST_COUNT;
               end
            end
         end
         ST_COUNT: begin
            if (word_valid) begin
               if (end_addr > LIMIT) begin
                  state_d = ST_ERROR;
               end else begin
                  count_d = word[ADDR_W:0];
                  state_d = (word == 32'd0) ? ST_CHECK : ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (word_valid) begin
               we_d    = 1'b1;
               addr_d  = base_q + wl_q[ADDR_W-1:0];
               wdata_d = word;
               wl_d    = wl_q + 1'b1;
               csum_d  = csum_q + word;
               if (wl_d == count_q) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (word_valid) state_d = (word == csum_q) ? ST_DONE : ST_ERROR;
         end
         default: ;
      endcase
      rdy_d = (state_d != ST_DONE) && (state_d != ST_ERROR);
   end

   always_ff @(posedge clk_x) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         count_q <= '0;
         wl_q    <= '0;
         csum_q  <= 32'd0;
         rdy_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         count_q <= count_d;
         wl_q    <= wl_d;
         csum_q  <= csum_d;
         rdy_q   <= rdy_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign rx_ready     = rdy_q;
   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign words_loaded = wl_q;
   assign cpu_hold     = (state_q != ST_DONE);
   assign load_done    = (state_q == ST_DONE);
   assign load_err     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as frames are
// sent and retired by a write monitor; status outputs are checked at decision points.
module tb_imem_loader;

   logic        clk_x = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   logic [10:0] words_loaded;

   typedef struct {
      logic [9:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] nom_d [5] = '{32'hc0200001, 32'hc0400002, 32'h00611000,
                              32'h48830002, 32'hc4800003};

   imem_loader #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk_x        (clk_x),
      .rst_n        (rst_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk_x = ~clk_x;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk_x) begin
      if (mem_we !== 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("we_unexpected", 64'(mem_we), 64'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(e.a));
            chk("wr_data", 64'(mem_wdata), 64'(e.d));
         end
      end
   end

   // Called at a negedge; returns at the negedge just after the handshake edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int budget = 0;
      repeat (gap) @(negedge clk_x);
      while (rx_ready !== 1'b1 && budget < 50) begin
         @(negedge clk_x);
         budget++;
      end
      if (rx_ready !== 1'b1) begin
         chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
      end else begin
         rx_data  = b;
         rx_valid = 1'b1;
         @(negedge clk_x);
         rx_valid = 1'b0;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_max, input logic exp_we);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[31-8*i -: 8], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      end
      chk("we_latency", 64'(mem_we), 64'(exp_we));
   endtask

   task automatic run_frame(input logic [31:0] start, input logic [31:0] csum, input int gap);
      for (int i = 0; i < 5; i++) begin
         wr_t e;
         e.a = 10'(start + 32'(i));
         e.d = nom_d[i];
         exp_q.push_back(e);
      end
      send_word(start, gap, 1'b0);
      send_word(32'd5, gap, 1'b0);
      for (int i = 0; i < 5; i++) send_word(nom_d[i], gap, 1'b1);
      send_word(csum, gap, 1'b0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
      chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
      chk({tag, "_load_done"}, 64'(load_done), 64'd0);
      chk({tag, "_load_err"}, 64'(load_err), 64'd0);
      chk({tag, "_words"}, 64'(words_loaded), 64'd0);
   endtask

   task automatic do_reset(input string tag);
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      @(negedge clk_x);
      check_reset_vals(tag);
      exp_q.delete();
      rst_n = 1'b1;
      @(negedge clk_x);
      chk({tag, "_ready_rise"}, 64'(rx_ready), 64'd1);
   endtask

   task automatic check_done(input string tag, input logic [10:0] words);
      chk({tag, "_done"}, 64'(load_done), 64'd1);
      chk({tag, "_hold"}, 64'(cpu_hold), 64'd0);
      chk({tag, "_err"}, 64'(load_err), 64'd0);
      chk({tag, "_ready"}, 64'(rx_ready), 64'd0);
      chk({tag, "_words"}, 64'(words_loaded), 64'(words));
      chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      @(negedge clk_x);
      do_reset("rst0");

      // Nominal load, then bytes offered while not ready must be ignored.
      run_frame(32'd1, 32'h8dc41008, 0);
      check_done("nom", 11'd5);
      rx_valid = 1'b1;
      rx_data  = 8'hff;
      repeat (5) @(negedge clk_x);
      rx_valid = 1'b0;
      check_done("ignored", 11'd5);

      do_reset("rst1");
      run_frame(32'd1, 32'h8dc41009, 0);
      chk("badsum_err", 64'(load_err), 64'd1);
      chk("badsum_hold", 64'(cpu_hold), 64'd1);
      chk("badsum_done", 64'(load_done), 64'd0);
      chk("badsum_words", 64'(words_loaded), 64'd5);
      chk("badsum_pending", 64'(exp_q.size()), 64'd0);

      do_reset("rst2");
      send_word(32'd1020, 0, 1'b0);
      chk("range_early", 64'(load_err), 64'd0);
      send_word(32'd5, 0, 1'b0);
      chk("range_err", 64'(load_err), 64'd1);
      chk("range_ready", 64'(rx_ready), 64'd0);
      chk("range_words", 64'(words_loaded), 64'd0);

      do_reset("rst3");
      send_word(32'h00000400, 0, 1'b0);
      chk("start_err", 64'(load_err), 64'd1);
      chk("start_hold", 64'(cpu_hold), 64'd1);

      do_reset("rst4");
      send_word(32'd0, 0, 1'b0);
      send_word(32'd0, 0, 1'b0);
      chk("empty_early", 64'(load_done), 64'd0);
      send_word(32'd0, 0, 1'b0);
      check_done("empty", 11'd0);

      do_reset("rst5");
      run_frame(32'd1, 32'h8dc41008, 3);
      check_done("gap", 11'd5);

      // Abort after the 2nd byte of data word 3: only two writes may happen.
      do_reset("rst6");
      for (int i = 0; i < 2; i++) begin
         wr_t e;
         e.a = 10'(i + 1);
         e.d = nom_d[i];
         exp_q.push_back(e);
      end
      send_word(32'd1, 0, 1'b0);
      send_word(32'd5, 0, 1'b0);
      send_word(nom_d[0], 0, 1'b1);
      send_word(nom_d[1], 0, 1'b1);
      send_byte(nom_d[2][31:24], 0);
      send_byte(nom_d[2][23:16], 0);
      chk("abort_pending", 64'(exp_q.size()), 64'd0);
      chk("abort_words", 64'(words_loaded), 64'd2);
      do_reset("abort");
      repeat (3) @(negedge clk_x);
      run_frame(32'd1, 32'h8dc41008, 0);
      check_done("reload", 11'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
